// File: rtl/ps2_keypad_pkg.sv
// Shared types and constants for the PS/2 keyboard to NES-pad translator.
package ps2_keypad_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_e;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_REL   = 8'hF0;

    // Set-2 scancodes; the four arrows are only valid behind an E0 prefix
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_A      = 8'h22;
    localparam logic [7:0] SC_B      = 8'h1A;
    localparam logic [7:0] SC_SELECT = 8'h12;
    localparam logic [7:0] SC_START  = 8'h5A;

    localparam logic [2:0] JOY_RIGHT  = 3'd0;
    localparam logic [2:0] JOY_LEFT   = 3'd1;
    localparam logic [2:0] JOY_DOWN   = 3'd2;
    localparam logic [2:0] JOY_UP     = 3'd3;
    localparam logic [2:0] JOY_A      = 3'd4;
    localparam logic [2:0] JOY_B      = 3'd5;
    localparam logic [2:0] JOY_SELECT = 3'd6;
    localparam logic [2:0] JOY_START  = 3'd7;

endpackage

// File: rtl/ps2_keypad_rx.sv
// PS/2 frame deserializer: synchronizes the line, assembles 11-bit frames and
// reports a byte or a frame error as one-cycle pulses.
module ps2_rx
    import ps2_keypad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_prev_q;
    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          fall, din;

    assign fall = clk_prev_q & ~clk_sync_q[1];
    assign din  = data_sync_q[1];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_ok_q    <= 1'b0;
            tmo_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_ok_q    <= par_ok_d;
            tmo_q       <= tmo_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        tmo_d     = (fall || state_q == S_IDLE) ? '0 : tmo_q + 1'b1;

        // A stalled keyboard must not wedge the FSM mid-frame
        if (state_q != S_IDLE && !fall && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!din) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_ok_d = ^{shift_q, din};
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    if (din && par_ok_q) valid_d = 1'b1;
                    else                 err_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign byte_o       = shift_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard front end: decodes E0/F0 prefixed scancodes into key events
// and maintains a held NES joypad state from a fixed key map.
module ps2_keypad
    import ps2_keypad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_release_o,
    output logic       key_strobe_o,
    output logic       frame_err_o,
    output logic [7:0] joy_o
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .ps2_clk_i    (ps2_clk_i),
        .ps2_data_i   (ps2_data_i),
        .byte_o       (rx_byte),
        .byte_valid_o (rx_valid),
        .frame_err_o  (rx_err)
    );

    logic       ext_q, ext_d, rel_q, rel_d;
    logic [7:0] code_q, code_d;
    logic       kext_q, kext_d, krel_q, krel_d;
    logic       strobe_q, strobe_d;
    logic [7:0] joy_q, joy_d;
    logic       map_hit;
    logic [2:0] map_idx;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            code_q   <= '0;
            kext_q   <= 1'b0;
            krel_q   <= 1'b0;
            strobe_q <= 1'b0;
            joy_q    <= '0;
        end else begin
            ext_q    <= ext_d;
            rel_q    <= rel_d;
            code_q   <= code_d;
            kext_q   <= kext_d;
            krel_q   <= krel_d;
            strobe_q <= strobe_d;
            joy_q    <= joy_d;
        end
    end

    // Arrows need the E0 prefix, the action keys must not have it
    always_comb begin
        map_hit = 1'b0;
        map_idx = '0;
        case (rx_byte)
            SC_RIGHT:  begin map_hit = ext_q;  map_idx = JOY_RIGHT;  end
            SC_LEFT:   begin map_hit = ext_q;  map_idx = JOY_LEFT;   end
            SC_DOWN:   begin map_hit = ext_q;  map_idx = JOY_DOWN;   end
            SC_UP:     begin map_hit = ext_q;  map_idx = JOY_UP;     end
            SC_A:      begin map_hit = !ext_q; map_idx = JOY_A;      end
            SC_B:      begin map_hit = !ext_q; map_idx = JOY_B;      end
            SC_SELECT: begin map_hit = !ext_q; map_idx = JOY_SELECT; end
            SC_START:  begin map_hit = !ext_q; map_idx = JOY_START;  end
            default:   begin map_hit = 1'b0;   map_idx = '0;         end
        endcase
    end

    always_comb begin
        ext_d    = ext_q;
        rel_d    = rel_q;
        code_d   = code_q;
        kext_d   = kext_q;
        krel_d   = krel_q;
        strobe_d = 1'b0;
        joy_d    = joy_q;
        if (rx_valid) begin
            if (rx_byte == PFX_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PFX_REL) begin
                rel_d = 1'b1;
            end else begin
                code_d   = rx_byte;
                kext_d   = ext_q;
                krel_d   = rel_q;
                strobe_d = 1'b1;
                ext_d    = 1'b0;
                rel_d    = 1'b0;
                if (map_hit) joy_d[map_idx] = ~rel_q;
            end
        end
    end

    assign key_code_o    = code_q;
    assign key_ext_o     = kext_q;
    assign key_release_o = krel_q;
    assign key_strobe_o  = strobe_q;
    assign frame_err_o   = rx_err;
    assign joy_o         = joy_q;

endmodule

// File: tb/tb_ps2_keypad.sv
// Directed plus randomized frames driven into ps2_keypad, checked against a
// byte-level model of the prefix decoder and joypad map.
module tb_ps2_keypad;

    localparam int TMO = 4095;
    localparam int H   = 8;   // clk cycles per PS/2 clock half period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code, joy;
    logic       key_ext, key_release, key_strobe, frame_err;

    ps2_keypad #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .ps2_clk_i     (ps2_clk),
        .ps2_data_i    (ps2_data),
        .key_code_o    (key_code),
        .key_ext_o     (key_ext),
        .key_release_o (key_release),
        .key_strobe_o  (key_strobe),
        .frame_err_o   (frame_err),
        .joy_o         (joy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (key_strobe) strobe_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: prefix flags, last key event and held pad bits
    logic [7:0] mcode [8] = '{8'h74, 8'h6B, 8'h72, 8'h75, 8'h22, 8'h1A, 8'h12, 8'h5A};
    bit         mext  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit         m_ext, m_rel, m_kext, m_krel;
    logic [7:0] m_code, m_joy;

    task automatic model_reset();
        m_ext = 0; m_rel = 0; m_kext = 0; m_krel = 0; m_code = 8'h00; m_joy = 8'h00;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit strobe);
        strobe = 0;
        if (b == 8'hE0)      m_ext = 1;
        else if (b == 8'hF0) m_rel = 1;
        else begin
            strobe = 1;
            m_code = b; m_kext = m_ext; m_krel = m_rel;
            for (int i = 0; i < 8; i++)
                if (mcode[i] == b && mext[i] == m_ext) m_joy[i] = !m_rel;
            m_ext = 0; m_rel = 0;
        end
    endtask

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".code"}, key_code, m_code);
        chk({tag, ".ext"}, key_ext, m_kext);
        chk({tag, ".rel"}, key_release, m_krel);
        chk({tag, ".joy"}, joy, m_joy);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int  s0, e0, first;
        bit  good, exp_s;
        good  = !bad_par && !bad_stop;
        exp_s = 0;
        if (good) model_byte(b, exp_s);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        s0 = strobe_cnt; e0 = err_cnt; first = -1;
        ps2_data = !bad_stop;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b0;
        for (int k = 1; k <= H; k++) begin
            @(negedge clk);
            if (key_strobe && first < 0) first = k;
        end
        ps2_clk = 1'b1;
        repeat (H) @(negedge clk);
        chk($sformatf("strobes_%02h", b), strobe_cnt - s0, int'(exp_s));
        chk($sformatf("errs_%02h", b), err_cnt - e0, int'(!good));
        // 2-FF synchronizer plus edge detect, then byte valid, then strobe
        if (exp_s) chk($sformatf("latency_%02h", b), first, 4);
        check_outputs($sformatf("frame_%02h", b));
    endtask

    initial begin
        int s0, e0;
        model_reset();
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_outputs("reset");
        chk("reset.strobe", key_strobe, 0);
        chk("reset.ferr", frame_err, 0);

        send_frame(8'h5A, 0, 0);
        chk("start_joy", joy, 8'h80);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h5A, 0, 0);
        chk("start_rel_joy", joy, 8'h00);

        send_frame(8'hE0, 0, 0);
        send_frame(8'h75, 0, 0);
        send_frame(8'h22, 0, 0);
        chk("up_a_joy", joy, 8'h18);
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        chk("up_rel_joy", joy, 8'h10);

        send_frame(8'h5A, 1, 0);
        send_frame(8'h5A, 0, 1);
        send_frame(8'h5A, 0, 0);
        send_frame(8'h5A, 0, 0);
        chk("typematic_joy", joy, 8'h90);

        s0 = strobe_cnt; e0 = err_cnt;
        ps2_bit(1'b1);
        repeat (4) @(negedge clk);
        chk("badstart.err", err_cnt - e0, 1);
        chk("badstart.strobe", strobe_cnt - s0, 0);

        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'($urandom_range(0, 1)));
        repeat (TMO - 50) @(negedge clk);
        chk("tmo.early", err_cnt - e0, 0);
        repeat (80) @(negedge clk);
        chk("tmo.err", err_cnt - e0, 1);
        check_outputs("tmo");
        send_frame(8'h1A, 0, 0);
        chk("tmo_b_joy", joy, 8'hB0);

        send_frame(8'hE0, 0, 0);
        ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs("midreset");
        chk("midreset.strobe", key_strobe, 0);
        send_frame(8'h74, 0, 0);
        chk("noext_joy", joy, 8'h00);
        chk("noext_ext", key_ext, 0);

        for (int n = 0; n < 40; n++) begin
            int r, f;
            logic [7:0] b;
            r = $urandom_range(0, 10);
            if (r < 8)       b = mcode[r];
            else if (r == 8) b = 8'hE0;
            else if (r == 9) b = 8'hF0;
            else             b = 8'($urandom);
            f = $urandom_range(0, 11);
            send_frame(b, f == 0, f == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

endmodule

// File: doc/ps2_keypad.md
PS2_KEYPAD -- requirements
Module: ps2_keypad

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 4095, clk cycles without a ps2_clk falling edge before a partial frame is abandoned.
REQ-002 clk  input  1  system clock; all logic is in this single clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ps2_clk  input  1  PS/2 clock from the keyboard serializer; asynchronous to clk; idles high.
REQ-005 ps2_data  input  1  PS/2 data; sampled on the ps2_clk falling edge.
REQ-006 key_code  output  8  last non-prefix scancode.
REQ-007 key_ext  output  1  key_code was preceded by E0.
REQ-008 key_release  output  1  key_code was preceded by F0.
REQ-009 key_strobe  output  1  one-clk pulse: key_code/key_ext/key_release updated.
REQ-010 frame_err  output  1  one-clk pulse: parity, start, stop or timeout error.
REQ-011 joy  output  8  held NES pad state, 1 = pressed: bit0 right, 1 left, 2 down, 3 up, 4 A, 5 B, 6 select, 7 start.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; a falling edge is synchronized-previous=1 and synchronized-current=0.
REQ-013 Frame FSM states: IDLE, DATA, PARITY, STOP; all transitions occur only on a falling edge, except timeout.
REQ-014 IDLE: on an edge, data=0 -> DATA with bit counter 0; data=1 -> stay IDLE and pulse frame_err.
REQ-015 DATA: shift data in LSB first; after 8 bits -> PARITY.
REQ-016 PARITY: require odd parity over the 8 data bits plus the parity bit; record pass/fail -> STOP.
REQ-017 STOP: data=1 and parity pass -> byte valid; otherwise frame_err; always -> IDLE.
REQ-018 Timeout: a counter clears on every edge and counts while the state is not IDLE; reaching TIMEOUT_CYCLES -> IDLE with frame_err, and the partial byte is discarded.
REQ-019 Byte valid is asserted in the clk cycle after the stop-bit edge is detected.
REQ-020 Decoder: byte E0 sets the ext flag; byte F0 sets the rel flag; neither produces key_strobe.
REQ-021 Any other byte: key_code<=byte, key_ext<=ext, key_release<=rel, key_strobe=1 in the cycle after byte valid; ext and rel clear in the same cycle.
REQ-022 Total latency: key_strobe is high exactly 2 clk cycles after the stop-bit edge detection.
REQ-023 A frame error SHALL leave ext, rel, key outputs and joy unchanged.
REQ-024 Joypad map (ext flag required where noted): right E0 74, left E0 6B, down E0 72, up E0 75, A 22, B 1A, select 12, start 5A.
REQ-025 On a key event matching the map, the corresponding joy bit is set if release=0 and cleared if release=1, in the same cycle as key_strobe.
REQ-026 Unmapped codes, and mapped codes with the wrong ext flag, leave joy unchanged.
REQ-027 Opposite directions (left+right, up+down) may be set simultaneously; no masking.
REQ-028 Repeated make codes (typematic) are idempotent on joy.

Reset
REQ-029 Reset SHALL put the FSM in IDLE and clear the bit counter, timeout counter, ext, rel and the synchronizers (to 1).
REQ-030 Reset values: key_code=00, key_ext=0, key_release=0, key_strobe=0, frame_err=0, joy=00.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; the first edge after release is treated as IDLE handling.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the eight scancode constants, the E0/F0 prefix constants and the joy bit indices.
REQ-033 The frame deserializer (REQ-012..019) SHALL be a sub-module ps2_rx with outputs byte[7:0], byte_valid and frame_err; ps2_keypad holds the decoder and joy logic.

Verification
REQ-034 Frame 5A, parity 1, stop 1 -> key_strobe 2 clk after the stop edge, key_code=5A, ext=0, rel=0, joy=80.
REQ-035 Frames F0,5A after REQ-034 -> single strobe with rel=1, joy=00; F0 alone produces no strobe.
REQ-036 Frames E0,75 then 22 -> joy=18; then E0,F0,75 -> strobe with ext=1, rel=1, joy=10.
REQ-037 Frame 5A with parity 0 -> frame_err pulse, no strobe, joy unchanged; the next good frame decodes normally.
REQ-038 Start bit + 4 data bits, then idle for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; the following full frame 1A sets joy bit5.
REQ-039 Reset pulse after E0 and 3 bits of the next frame -> all outputs at reset values; the subsequent frame 74 (no E0) leaves joy=00 and strobes with ext=0.
